// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multicycle control FSM for the RFplusALU datapath. Decodes
//                the opcode Ins[15:11] and steps FETCH/DECODE/EXE/MEM/WB,
//                driving the RF, ALU, PC and data-memory strobes.
//                Optional build macro MCTRL_PERF_EN adds the InstCnt and
//                CycleCnt performance counter outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [15:0]       Ins,
    input  logic              MemReady,
    output logic              IRload,
    output logic              PCload,
    output logic [1:0]        PCsel,
    output logic              MemRd,
    output logic              MemWr,
    output logic              WBRF,
    output logic              WBresource,
    output logic              RBresource,
    output logic              OprandB,
    output logic              LI,
    output logic              Buff_IDEXE,
    output logic              PSW_C,
    output logic              ALUop,
    output logic              Flag,
    output logic              PSWload,
    output logic              OutRload,
    output logic              Halted,
    output logic              IllegalOp,
    output logic              BusErr,
`ifdef MCTRL_PERF_EN
    output logic [PERF_W-1:0] InstCnt,
    output logic [PERF_W-1:0] CycleCnt,
`endif
    output logic [2:0]        State
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [4:0] c_OP_NOP    = 5'b00000;
    localparam logic [4:0] c_OP_LHI    = 5'b00001;
    localparam logic [4:0] c_OP_LLI    = 5'b00010;
    localparam logic [4:0] c_OP_LDR_RI = 5'b00011;
    localparam logic [4:0] c_OP_LDR_RR = 5'b00100;
    localparam logic [4:0] c_OP_STR_RI = 5'b00101;
    localparam logic [4:0] c_OP_STR_RR = 5'b00110;
    localparam logic [4:0] c_OP_ADD    = 5'b00111;
    localparam logic [4:0] c_OP_ADC    = 5'b01000;
    localparam logic [4:0] c_OP_SUB    = 5'b01001;
    localparam logic [4:0] c_OP_SBB    = 5'b01010;
    localparam logic [4:0] c_OP_CMP    = 5'b01011;
    localparam logic [4:0] c_OP_ADDI   = 5'b01100;
    localparam logic [4:0] c_OP_SUBI   = 5'b01101;
    localparam logic [4:0] c_OP_MOV    = 5'b01110;
    localparam logic [4:0] c_OP_JAL    = 5'b01111;
    localparam logic [4:0] c_OP_JR     = 5'b10000;
    localparam logic [4:0] c_OP_OUTR   = 5'b10001;
    localparam logic [4:0] c_OP_HLT    = 5'b11111;

    localparam int c_WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LIM = c_WAIT_W'(MEM_WAIT_MAX);

    state_t              r_state;
    state_t              w_next;
    logic                r_run;      // low for the single idle cycle after reset release
    logic [4:0]          r_opc;      // opcode captured in DECODE for EXE/MEM/WB
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_bus_err;
    logic [4:0]          w_op;
    logic                w_is_ldr;
    logic                w_is_str;
    logic                w_mem_timeout;
    logic                w_unused_ins;

    assign w_op          = Ins[15:11];
    assign w_unused_ins  = ^Ins[10:0];
    assign w_is_ldr      = (r_opc == c_OP_LDR_RI) || (r_opc == c_OP_LDR_RR);
    assign w_is_str      = (r_opc == c_OP_STR_RI) || (r_opc == c_OP_STR_RR);
    assign w_mem_timeout = (r_state == S_MEM) && !MemReady && (r_wait == c_WAIT_LIM);
    assign State         = r_state;
    assign BusErr        = r_bus_err;

    // State register, captured opcode and post-reset run flag
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
            r_opc   <= 5'd0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            if (r_state == S_DECODE) begin
                r_opc <= w_op;
            end
        end
    end

    // MEM wait counter (restarts at 0 on every MEM entry) and sticky bus error
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_wait    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state == S_MEM) begin
                r_wait <= r_wait + c_WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            if (w_mem_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next     = r_state;
        IRload     = 1'b0;
        PCload     = 1'b0;
        PCsel      = 2'd0;
        MemRd      = 1'b0;
        MemWr      = 1'b0;
        WBRF       = 1'b0;
        WBresource = 1'b0;
        RBresource = 1'b0;
        OprandB    = 1'b0;
        LI         = 1'b0;
        Buff_IDEXE = 1'b0;
        PSW_C      = 1'b0;
        ALUop      = 1'b0;
        Flag       = 1'b0;
        PSWload    = 1'b0;
        OutRload   = 1'b0;
        Halted     = 1'b0;
        IllegalOp  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (r_run) begin
                    IRload = 1'b1;
                    PCload = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = S_FETCH;
                case (w_op)
                    c_OP_NOP: ;
                    c_OP_LHI: begin RBresource = 1'b1; Buff_IDEXE = 1'b1; w_next = S_WB; end
                    c_OP_LLI: begin LI = 1'b1; Buff_IDEXE = 1'b1; w_next = S_WB; end
                    c_OP_LDR_RI, c_OP_STR_RI, c_OP_ADDI, c_OP_SUBI: begin
                        OprandB = 1'b1; Buff_IDEXE = 1'b1; w_next = S_EXE;
                    end
                    c_OP_LDR_RR, c_OP_STR_RR, c_OP_ADD, c_OP_ADC,
                    c_OP_SUB, c_OP_SBB, c_OP_CMP: begin
                        Buff_IDEXE = 1'b1; w_next = S_EXE;
                    end
                    c_OP_MOV: begin Buff_IDEXE = 1'b1; w_next = S_WB; end
                    c_OP_JAL: begin WBRF = 1'b1; WBresource = 1'b1; PCload = 1'b1; PCsel = 2'd2; end
                    c_OP_JR:  begin RBresource = 1'b1; PCload = 1'b1; PCsel = 2'd1; end
                    c_OP_OUTR: begin Buff_IDEXE = 1'b1; OutRload = 1'b1; end
                    c_OP_HLT: w_next = S_HALT;
                    default:  IllegalOp = 1'b1;
                endcase
            end
            S_EXE: begin
                w_next = S_WB;
                // ALU code {PSW_C,ALUop,Flag}: ADD=100 ADC=101 SUB=010 SBB=011
                case (r_opc)
                    c_OP_LDR_RI, c_OP_LDR_RR, c_OP_STR_RI, c_OP_STR_RR: begin
                        PSW_C = 1'b1; w_next = S_MEM;
                    end
                    c_OP_ADD, c_OP_ADDI: begin PSW_C = 1'b1; PSWload = 1'b1; end
                    c_OP_ADC: begin PSW_C = 1'b1; Flag = 1'b1; PSWload = 1'b1; end
                    c_OP_SUB, c_OP_SUBI: begin ALUop = 1'b1; PSWload = 1'b1; end
                    c_OP_SBB: begin ALUop = 1'b1; Flag = 1'b1; PSWload = 1'b1; end
                    c_OP_CMP: begin ALUop = 1'b1; PSWload = 1'b1; w_next = S_FETCH; end
                    default:  w_next = S_FETCH;
                endcase
                RBresource = w_is_str;
            end
            S_MEM: begin
                MemRd = w_is_ldr;
                MemWr = w_is_str;
                // A MemReady on the limit cycle still counts as success
                if (MemReady) begin
                    w_next = w_is_ldr ? S_WB : S_FETCH;
                end else if (r_wait == c_WAIT_LIM) begin
                    w_next = S_FETCH;
                end
            end
            S_WB: begin
                WBRF       = 1'b1;
                WBresource = !w_is_ldr;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

`ifdef MCTRL_PERF_EN
    logic [PERF_W-1:0] r_inst_cnt;
    logic [PERF_W-1:0] r_cycle_cnt;

    // Instruction count on each FETCH->DECODE step, cycle count outside HALT
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_inst_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if ((r_state == S_FETCH) && (w_next == S_DECODE)) begin
                r_inst_cnt <= r_inst_cnt + PERF_W'(1);
            end
            if (r_state != S_HALT) begin
                r_cycle_cnt <= r_cycle_cnt + PERF_W'(1);
            end
        end
    end

    assign InstCnt  = r_inst_cnt;
    assign CycleCnt = r_cycle_cnt;
`else
    localparam int c_unused_perf_w = PERF_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl: directed opcode
//                table, randomized instruction stream against a per-cycle
//                reference trace, reset-abort and HALT sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int MEM_WAIT_MAX = 15;
    localparam int PERF_W       = 16;

    logic        clk = 1'b0;
    logic        Reset;
    logic [15:0] Ins;
    logic        MemReady;
    logic        IRload, PCload, MemRd, MemWr, WBRF, WBresource, RBresource;
    logic        OprandB, LI, Buff_IDEXE, PSW_C, ALUop, Flag, PSWload, OutRload;
    logic        Halted, IllegalOp, BusErr;
    logic [1:0]  PCsel;
    logic [2:0]  State;
`ifdef MCTRL_PERF_EN
    logic [PERF_W-1:0] InstCnt, CycleCnt;
`endif

    multicycle_ctrl #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .PERF_W(PERF_W)) dut (
        .clk(clk), .Reset(Reset), .Ins(Ins), .MemReady(MemReady),
        .IRload(IRload), .PCload(PCload), .PCsel(PCsel),
        .MemRd(MemRd), .MemWr(MemWr), .WBRF(WBRF), .WBresource(WBresource),
        .RBresource(RBresource), .OprandB(OprandB), .LI(LI), .Buff_IDEXE(Buff_IDEXE),
        .PSW_C(PSW_C), .ALUop(ALUop), .Flag(Flag), .PSWload(PSWload),
        .OutRload(OutRload), .Halted(Halted), .IllegalOp(IllegalOp), .BusErr(BusErr),
`ifdef MCTRL_PERF_EN
        .InstCnt(InstCnt), .CycleCnt(CycleCnt),
`endif
        .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irload;  logic pcload; logic [1:0] pcsel;
        logic       memrd;   logic memwr;  logic wbrf;  logic wbres;
        logic       rbres;   logic oprandb; logic li;   logic buff;
        logic       psw_c;   logic aluop;  logic flag;  logic pswload;
        logic       outrload; logic halted; logic illegal; logic buserr;
        logic [2:0] state;
    } outs_t;

    typedef struct {
        logic [15:0] ins;
        int          rdy;   // MEM cycle (1-based) on which MemReady is high, 0 = never
        int          cpi;
    } vec_t;

    outs_t act;
    assign act = {IRload, PCload, PCsel, MemRd, MemWr, WBRF, WBresource, RBresource,
                  OprandB, LI, Buff_IDEXE, PSW_C, ALUop, Flag, PSWload, OutRload,
                  Halted, IllegalOp, BusErr, State};

    int    total = 0;
    int    bad   = 0;
    bit    model_be;
    int    model_inst;
    outs_t exp_q[$];
    bit    rdy_q[$];
    vec_t  tbl[22];

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    function automatic outs_t fetch_word();
        outs_t o;
        o = '0; o.irload = 1'b1; o.pcload = 1'b1; o.buserr = model_be;
        return o;
    endfunction

    function automatic void push(input outs_t o, input bit r);
        outs_t t;
        t = o; t.buserr = model_be;
        exp_q.push_back(t);
        rdy_q.push_back(r);
    endfunction

    // Reference: expected per-cycle outputs of one instruction from the opcode map
    function automatic void build(input logic [15:0] ins, input int ready_at);
        logic [4:0] op;
        outs_t      o;
        bit         is_ldr, is_str, go_exe, go_wb, r;
        op = ins[15:11];
        exp_q.delete(); rdy_q.delete();
        is_ldr = (op == 5'd3) || (op == 5'd4);
        is_str = (op == 5'd5) || (op == 5'd6);
        go_exe = 1'b0; go_wb = 1'b0;
        push(fetch_word(), 1'($urandom));
        o = '0; o.state = 3'd1;
        case (op)
            5'd0:  ;
            5'd1:  begin o.rbres = 1; o.buff = 1; go_wb = 1; end
            5'd2:  begin o.li = 1; o.buff = 1; go_wb = 1; end
            5'd3, 5'd5, 5'd12, 5'd13: begin o.oprandb = 1; o.buff = 1; go_exe = 1; end
            5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin o.buff = 1; go_exe = 1; end
            5'd14: begin o.buff = 1; go_wb = 1; end
            5'd15: begin o.wbrf = 1; o.wbres = 1; o.pcload = 1; o.pcsel = 2'd2; end
            5'd16: begin o.rbres = 1; o.pcload = 1; o.pcsel = 2'd1; end
            5'd17: begin o.buff = 1; o.outrload = 1; end
            5'd31: ;
            default: o.illegal = 1;
        endcase
        push(o, 1'($urandom));
        if (go_exe) begin
            o = '0; o.state = 3'd2;
            if (op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd12}) {o.psw_c, o.aluop, o.flag} = 3'b100;
            else if (op == 5'd8)                               {o.psw_c, o.aluop, o.flag} = 3'b101;
            else if (op inside {5'd9, 5'd11, 5'd13})           {o.psw_c, o.aluop, o.flag} = 3'b010;
            else                                               {o.psw_c, o.aluop, o.flag} = 3'b011;
            o.pswload = (op >= 5'd7) && (op <= 5'd13);
            o.rbres   = is_str;
            push(o, 1'($urandom));
            if (is_ldr || is_str) begin
                for (int k = 0; k <= MEM_WAIT_MAX; k++) begin
                    r = (k + 1 == ready_at);
                    o = '0; o.state = 3'd3; o.memrd = is_ldr; o.memwr = is_str;
                    push(o, r);
                    if (r) begin
                        go_wb = is_ldr;
                        break;
                    end
                    if (k == MEM_WAIT_MAX) model_be = 1'b1;
                end
            end else begin
                go_wb = (op != 5'd11);
            end
        end
        if (go_wb) begin
            o = '0; o.state = 3'd4; o.wbrf = 1; o.wbres = !is_ldr;
            push(o, 1'($urandom));
        end
    endfunction

    // Cycles per instruction from the published CPI rules
    function automatic int exp_cpi(input logic [4:0] op, input int r);
        bit ok;
        int w;
        ok = (r >= 1) && (r <= MEM_WAIT_MAX + 1);
        w  = ok ? r - 1 : MEM_WAIT_MAX;
        case (op)
            5'd1, 5'd2, 5'd11, 5'd14:              return 3;
            5'd3, 5'd4:                            return ok ? 5 + w : 4 + w;
            5'd5, 5'd6:                            return 4 + w;
            5'd7, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13: return 4;
            default:                               return 2;
        endcase
    endfunction

    // Runs one instruction from a FETCH negedge to the next FETCH negedge
    task automatic run_instr(input logic [15:0] ins, input int ready_at, output int cpi);
        int cyc;
        bit fin;
        build(ins, ready_at);
        Ins = ins;
        model_inst++;
        cyc = 0; fin = 0;
        while (!fin) begin
            MemReady = (cyc < rdy_q.size()) ? rdy_q[cyc] : 1'b0;
            if (cyc < exp_q.size()) chk("trace", 32'(act), 32'(exp_q[cyc]));
            else                    chk("trace_len", 32'(cyc), 32'(exp_q.size()));
            @(posedge clk); @(negedge clk);
            cyc++;
            if (State == 3'd0) fin = 1;
            else if (cyc >= 40) begin
                chk("timeout", 32'(State), 32'd0);
                fin = 1;
            end
        end
        cpi = cyc;
    endtask

    initial begin
        int          cpi;
        logic [4:0]  op;
        int          rdy;
        outs_t       o;
`ifdef MCTRL_PERF_EN
        logic [PERF_W-1:0] c0;
`endif
        tbl[0]  = '{16'h0000, 0, 2};   tbl[1]  = '{16'h0800, 0, 3};
        tbl[2]  = '{16'h1000, 0, 3};   tbl[3]  = '{16'h3800, 0, 4};
        tbl[4]  = '{16'h4000, 0, 4};   tbl[5]  = '{16'h4800, 0, 4};
        tbl[6]  = '{16'h5000, 0, 4};   tbl[7]  = '{16'h5800, 0, 3};
        tbl[8]  = '{16'h6000, 0, 4};   tbl[9]  = '{16'h6800, 0, 4};
        tbl[10] = '{16'h7000, 0, 3};   tbl[11] = '{16'h7800, 0, 2};
        tbl[12] = '{16'h8000, 0, 2};   tbl[13] = '{16'h8800, 0, 2};
        tbl[14] = '{16'h9000, 0, 2};   tbl[15] = '{16'h1800, 3, 7};
        tbl[16] = '{16'h2000, 1, 5};   tbl[17] = '{16'h2800, 1, 4};
        tbl[18] = '{16'h3000, 0, 19};  tbl[19] = '{16'h1800, 16, 20};
        tbl[20] = '{16'h2800, 17, 19}; tbl[21] = '{16'h0000, 0, 2};

        Reset = 1'b0; Ins = 16'h0; MemReady = 1'b0;
        model_be = 1'b0; model_inst = 0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'(act), 32'd0);
        Reset = 1'b1;
        #1 chk("idle_after_reset", 32'(act), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            run_instr(tbl[i].ins, tbl[i].rdy, cpi);
            chk($sformatf("cpi_tbl%0d", i), 32'(cpi), 32'(tbl[i].cpi));
        end
        chk("buserr_sticky", 32'(BusErr), 32'd1);

        for (int n = 0; n < 200; n++) begin
            op  = 5'($urandom_range(0, 30));
            rdy = $urandom_range(0, 18);
            run_instr({op, 11'($urandom)}, rdy, cpi);
            chk("cpi_rand", 32'(cpi), 32'(exp_cpi(op, rdy)));
        end

        // Reset asserted while an ADD sits in EXE
        Ins = 16'h3800;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("pre_reset_exe", 32'(State), 32'd2);
        Reset = 1'b0;
        #1 chk("reset_mid_exe", 32'(act), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("reset_hold", 32'(act), 32'd0);
        Reset = 1'b1; model_be = 1'b0; model_inst = 0;
        #1 chk("post_reset_idle", 32'(act), 32'd0);
        @(negedge clk);
        chk("post_reset_fetch", 32'(act), 32'(fetch_word()));
        run_instr(16'h3800, 0, cpi);
        chk("cpi_add_after_reset", 32'(cpi), 32'd4);

        // HLT: enters HALT and stays there regardless of Ins/MemReady
        Ins = 16'hF800; model_inst++;
        chk("hlt_fetch", 32'(act), 32'(fetch_word()));
        @(posedge clk); @(negedge clk);
        o = '0; o.state = 3'd1;
        chk("hlt_decode", 32'(act), 32'(o));
        @(posedge clk); @(negedge clk);
`ifdef MCTRL_PERF_EN
        c0 = CycleCnt;
`endif
        o = '0; o.state = 3'd5; o.halted = 1'b1;
        for (int k = 0; k < 20; k++) begin
            Ins = 16'($urandom); MemReady = 1'($urandom);
            chk("halt_hold", 32'(act), 32'(o));
            @(posedge clk); @(negedge clk);
        end
`ifdef MCTRL_PERF_EN
        chk("cyclecnt_frozen", 32'(CycleCnt), 32'(c0));
        chk("instcnt", 32'(InstCnt), 32'(model_inst));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
